// File: rtl/config_reg_pkg.sv
// Shared types and defaults for the double-buffered configuration
// register bank.
package config_reg_pkg;

  typedef enum logic [2:0] {
    adc0_reg         = 3'd0,
    adc1_reg         = 3'd1,
    temp_sensor0_reg = 3'd2,
    temp_sensor1_reg = 3'd3,
    analog_test      = 3'd4,
    digital_test     = 3'd5,
    amp_gain         = 3'd6,
    digital_config   = 3'd7
  } e_reg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } e_state;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  // reg 4 (analog_test) powers up as 16'hABCD, all others 0
  localparam logic [DEF_NUM_REGS*DEF_DATA_W-1:0] DEFAULT_RESET_VALS =
    128'h0000_0000_0000_ABCD_0000_0000_0000_0000;

endpackage

// File: rtl/config_reg_cell.sv
// One shadow/active register pair: byte-strobed writes land in
// shadow, commit copies shadow into active.
module config_reg_cell #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                commit_i,
  output logic [DATA_W-1:0]   shadow_o,
  output logic [DATA_W-1:0]   active_o,
  output logic                diff_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb_i[b]) shadow_d[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

  // commit takes the pre-edge shadow, so a same-edge write stays pending
  assign active_d = commit_i ? shadow_q : active_q;
  assign diff_o   = shadow_d != active_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/config_reg_bank.sv
// Double-buffered config register bank behind a valid/ready
// request/response port with strobes, RO masking, lock and errors.
module config_reg_bank
  import config_reg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = DEFAULT_RESET_VALS,
  parameter logic [NUM_REGS-1:0]        RO_MASK    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_wstrb,
  input  logic                       rd_active,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic                       commit,
  input  logic                       lock,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out,
  output logic                       pending
);

  logic [DATA_W-1:0]   shadow_w [NUM_REGS];
  logic [DATA_W-1:0]   active_w [NUM_REGS];
  logic [NUM_REGS-1:0] we;
  logic [NUM_REGS-1:0] diff;

  e_state            state_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              pending_q;

  logic              accept;
  logic              oob;
  logic              ro;
  logic              err;
  logic [DATA_W-1:0] rd;

  assign req_ready = reset && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign oob       = {1'b0, req_addr} >= (ADDR_W+1)'(NUM_REGS);

  always_comb begin
    ro = 1'b0;
    rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        ro = RO_MASK[i];
        rd = rd_active ? active_w[i] : shadow_w[i];
      end
    end
  end

  assign err = oob || (req_write && (ro || lock));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign we[i] = accept && req_write && !err &&
                   (req_addr == ADDR_W'(i));

    config_reg_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RESET_VALS[i*DATA_W +: DATA_W])
    ) u_cell (
      .clk      (clk),
      .rst_n    (reset),
      .we_i     (we[i]),
      .wstrb_i  (req_wstrb),
      .wdata_i  (req_wdata),
      .commit_i (commit),
      .shadow_o (shadow_w[i]),
      .active_o (active_w[i]),
      .diff_o   (diff[i])
    );

    assign cfg_out[i*DATA_W +: DATA_W] = active_w[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || req_write) ? '0 : rd;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= 1'b0;
    else        pending_q <= |diff;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign pending   = pending_q;

endmodule

// File: doc/config_reg_bank.md
Name: config_reg_bank

Overview:
Parametrised successor to the 8 x 16-bit config register file. It provides NUM_REGS registers of DATA_W bits, each with its own reset value, behind a valid/ready request/response handshake. Each register is double-buffered: writes land in a shadow copy, and a commit pulse transfers all shadows to the active copies that drive the analog/digital configuration bus. It also adds byte strobes, per-register read-only masking, a write lock and error responses.

Parameters:
DATA_W, 16, register width in bits; multiple of 8
NUM_REGS, 8, number of registers; 2..64
ADDR_W, $clog2(NUM_REGS), request address width
RESET_VALS, {NUM_REGS*DATA_W}, packed reset values, reg i at [i*DATA_W +: DATA_W]; default all 0 except reg 4 (analog_test) = 16'hABCD
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes reg i read-only on the bus

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  register index
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  byte enables for write
rd_active  in  1  read returns active copy (1) or shadow copy (0)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data; 0 on writes and errors
rsp_err  out  1  request rejected
commit  in  1  one-cycle pulse: all shadow -> active
lock  in  1  level; while high, all writes are rejected
cfg_out  out  NUM_REGS*DATA_W  active copies, flattened as RESET_VALS
pending  out  1  some shadow differs from its active copy

Behaviour:
- Reset (reset = 0, asynchronous):
  - shadow[i] = active[i] = RESET_VALS[i]
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, pending = 0, state = IDLE
  - req_ready = 0 while reset is low
- FSM, two states:
  - IDLE: req_ready = 1. A request is accepted on a clock edge with req_valid & req_ready; go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1, response fields held stable. On rsp_valid & rsp_ready go to IDLE.
  - Only one request is outstanding at a time; no back-to-back acceptance.
  - Throughput is 1 request per 2 cycles with rsp_ready held high.
- Latency: request accepted at edge N, response valid after edge N. The write effect is visible in shadow after edge N.
- Errors (rsp_err = 1, no state change, rsp_rdata = 0), evaluated with priority in this order:
  - req_addr >= NUM_REGS
  - write to an RO_MASK register
  - write while lock = 1
  - Reads are never blocked by lock or RO_MASK.
- Write: for each byte b with req_wstrb[b] = 1, shadow[addr] byte b = req_wdata byte b; other bytes are unchanged. wstrb = 0 is a legal no-op with no error.
- Read: rsp_rdata = rd_active ? active[addr] : shadow[addr], sampled at the accept edge.
- Commit:
  - On an edge with commit = 1, active[i] = shadow[i] for all i, using pre-edge shadow values.
  - Commit is independent of the FSM; it is honoured in IDLE or RESP.
- Simultaneous write accept and commit on the same edge: active takes the old shadow value; the new write stays in shadow, so pending = 1 afterwards.
- Simultaneous read of active and commit: the read returns the pre-commit active value.
- pending: registered; recomputed every edge as OR over i of (next shadow[i] != next active[i]).
- cfg_out: driven directly from the active registers; no glitch path from the request bus.
- Reset asserted mid-transaction: the response is dropped, all registers return to RESET_VALS and the FSM returns to IDLE after reset deasserts.

Decomposition:
- Package config_reg_pkg:
  - e_reg enum (adc0_reg .. digital_config)
  - DEFAULT_RESET_VALS constant
  - e_state {IDLE, RESP}
- One natural sub-module, config_reg_cell: one shadow/active register pair with strobed write and commit, instantiated NUM_REGS times via generate.
- The bank holds the FSM, address decode, error logic and the read mux.

Test Plan:
1. Reset then read analog_test (addr 4), rd_active = 0 -> rsp_rdata = 16'hABCD, rsp_err = 0. Read adc1_reg (addr 1) -> 16'h0000.
2. Write adc1_reg = 16'h4ACC, wstrb = 2'b11 -> shadow read 16'h4ACC, active read 16'h0000, pending = 1. Pulse commit -> cfg_out[31:16] = 16'h4ACC, pending = 0.
3. Write amp_gain (addr 6) = 16'h34F3 with wstrb = 2'b01, then 16'h9900 with wstrb = 2'b10 -> shadow reads 16'h99F3.
4. With RO_MASK = 8'h01, write adc0_reg = 16'h11BC -> rsp_err = 1, readback 0. With lock = 1, write digital_test = 16'h980D -> rsp_err = 1, unchanged. With NUM_REGS = 6, access addr 7 -> rsp_err = 1.
5. Write temp_sensor0_reg = 16'hF1A0 accepted on the same edge as commit -> active stays 0, shadow = 16'hF1A0, pending = 1. Second commit -> active = 16'hF1A0.
6. Hold rsp_ready = 0 for 5 cycles after a read -> rsp_valid and rsp_rdata held, req_ready = 0. Assert reset mid-hold -> rsp_valid = 0 immediately, digital_config (addr 7) reads its reset value after release.
